// File: rtl/lfsr_rng_bank.sv
// rtl/lfsr_rng_bank.sv - multi-channel Fibonacci LFSR random bank; optional RNG_LEAP_EN advances OUT_WIDTH steps per draw
module lfsr_rng_bank #(
    parameter int S_WIDTH   = 8,
    parameter int N_CH      = 3,
    parameter int OUT_WIDTH = 6,
    parameter int CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH*S_WIDTH-1:0]   seed_i,
    input  logic                      seed_valid_i,
    input  logic                      free_run_i,
    input  logic                      rnd_ready_i,
    output logic                      rnd_valid_o,
    output logic [N_CH*OUT_WIDTH-1:0] rnd_o,
    output logic                      seeded_o,
    output logic [CNT_WIDTH-1:0]      draw_cnt_o
);

    generate
        if (!(S_WIDTH == 8 || S_WIDTH == 16 || S_WIDTH == 32)) begin : g_bad_width
            $error("lfsr_rng_bank: S_WIDTH must be 8, 16 or 32");
        end
        if (OUT_WIDTH < 1 || OUT_WIDTH > S_WIDTH) begin : g_bad_out_width
            $error("lfsr_rng_bank: OUT_WIDTH must be in 1..S_WIDTH");
        end
    endgenerate

`ifdef RNG_LEAP_EN
    localparam int LEAP = OUT_WIDTH;
`else
    localparam int LEAP = 1;
`endif

    typedef enum logic {IDLE, RUN} fsm_e;

    fsm_e                    fsm_q, fsm_d;
    logic [N_CH*S_WIDTH-1:0] state_q, state_d;
    logic                    seeded_q, seeded_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    draw;
    logic                    step;

    // Widened copy lets every tap set be indexed without out-of-range selects.
    function automatic logic [S_WIDTH-1:0] lfsr_next(input logic [S_WIDTH-1:0] s);
        logic [31:0] w;
        logic        fb;
        w = 32'(s);
        case (S_WIDTH)
            8:       fb = w[7] ^ w[5] ^ w[4] ^ w[3];
            16:      fb = w[15] ^ w[14] ^ w[12] ^ w[3];
            default: fb = w[31] ^ w[21] ^ w[1] ^ w[0];
        endcase
        return {s[S_WIDTH-2:0], fb};
    endfunction

    function automatic logic [S_WIDTH-1:0] lfsr_advance(input logic [S_WIDTH-1:0] s);
        logic [S_WIDTH-1:0] t;
        t = s;
        for (int i = 0; i < LEAP; i++) begin
            t = lfsr_next(t);
        end
        return t;
    endfunction

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        seeded_d = seeded_q;
        cnt_d    = cnt_q;
        draw     = (fsm_q == RUN) && rnd_ready_i;
        step     = (fsm_q == RUN) && (draw || free_run_i);
        if (seed_valid_i) begin
            for (int k = 0; k < N_CH; k++) begin
                state_d[k*S_WIDTH +: S_WIDTH] =
                    (seed_i[k*S_WIDTH +: S_WIDTH] == '0) ? '1 : seed_i[k*S_WIDTH +: S_WIDTH];
            end
            fsm_d    = RUN;
            seeded_d = 1'b1;
        end else if (step) begin
            for (int k = 0; k < N_CH; k++) begin
                state_d[k*S_WIDTH +: S_WIDTH] = lfsr_advance(state_q[k*S_WIDTH +: S_WIDTH]);
            end
            if (draw) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= IDLE;
            state_q  <= '0;
            seeded_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            seeded_q <= seeded_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        rnd_o = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (fsm_q == RUN) begin
                rnd_o[k*OUT_WIDTH +: OUT_WIDTH] = state_q[k*S_WIDTH +: OUT_WIDTH];
            end
        end
    end

    assign rnd_valid_o = (fsm_q == RUN);
    assign seeded_o    = seeded_q;
    assign draw_cnt_o  = cnt_q;

endmodule

// File: tb/tb_lfsr_rng_bank.sv
// tb/tb_lfsr_rng_bank.sv - randomized reference-model bench for lfsr_rng_bank
module tb_lfsr_rng_bank;

    localparam int S  = 8;
    localparam int NC = 3;
    localparam int OW = 6;
    localparam int CW = 16;

`ifdef RNG_LEAP_EN
    localparam int LEAP = OW;
`else
    localparam int LEAP = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NC*S-1:0]   seed;
    logic              seed_valid;
    logic              free_run;
    logic              rdy;
    logic              valid_a, valid_b;
    logic [NC*OW-1:0]  rnd_a, rnd_b;
    logic              seeded_a, seeded_b;
    logic [CW-1:0]     cnt_a;
    logic [3:0]        cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned m_st[NC];
    bit          m_valid;
    bit          m_seeded;
    int unsigned m_cnt;

    always #5 clk = ~clk;

    lfsr_rng_bank #(.S_WIDTH(S), .N_CH(NC), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .seed_i(seed), .seed_valid_i(seed_valid),
        .free_run_i(free_run), .rnd_ready_i(rdy), .rnd_valid_o(valid_a),
        .rnd_o(rnd_a), .seeded_o(seeded_a), .draw_cnt_o(cnt_a));

    lfsr_rng_bank #(.S_WIDTH(S), .N_CH(NC), .OUT_WIDTH(OW), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .seed_i(seed), .seed_valid_i(seed_valid),
        .free_run_i(free_run), .rnd_ready_i(rdy), .rnd_valid_o(valid_b),
        .rnd_o(rnd_b), .seeded_o(seeded_b), .draw_cnt_o(cnt_b));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Taps 7,5,4,3 as a mask; feedback is the parity of the masked state.
    function automatic int unsigned ref_step(input int unsigned s);
        int unsigned fb;
        fb = $countones(s & 32'hB8) % 2;
        return ((s << 1) | fb) & 32'hFF;
    endfunction

    task automatic model_update();
        bit draw;
        if (rst) begin
            foreach (m_st[k]) m_st[k] = 0;
            m_valid = 0; m_seeded = 0; m_cnt = 0;
        end else if (seed_valid) begin
            foreach (m_st[k]) begin
                m_st[k] = (seed >> (k*S)) & 32'hFF;
                if (m_st[k] == 0) m_st[k] = 32'hFF;
            end
            m_valid = 1; m_seeded = 1;
        end else if (m_valid) begin
            draw = rdy;
            if (draw || free_run)
                foreach (m_st[k])
                    for (int i = 0; i < LEAP; i++) m_st[k] = ref_step(m_st[k]);
            if (draw) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_all(input string tag);
        logic [NC*OW-1:0] exp_rnd;
        int unsigned      lo;
        exp_rnd = '0;
        foreach (m_st[k]) begin
            lo = m_valid ? (m_st[k] & ((1 << OW) - 1)) : 0;
            exp_rnd[k*OW +: OW] = lo[OW-1:0];
        end
        check({tag, ".valid"}, 64'(valid_a), 64'(m_valid));
        check({tag, ".rnd"}, 64'(rnd_a), 64'(exp_rnd));
        check({tag, ".seeded"}, 64'(seeded_a), 64'(m_seeded));
        check({tag, ".cnt"}, 64'(cnt_a), 64'(m_cnt % (1 << CW)));
        check({tag, ".cnt4"}, 64'(cnt_b), 64'(m_cnt % 16));
        check({tag, ".rnd4"}, 64'(rnd_b), 64'(exp_rnd));
    endtask

    int unsigned seq8[8];
    logic [CW-1:0] cnt_before;
    logic [7:0]    st0;

    initial begin
        seq8 = '{32'h01, 32'h02, 32'h04, 32'h08, 32'h11, 32'h23, 32'h47, 32'h8E};
        rst = 1; seed = '0; seed_valid = 0; free_run = 0; rdy = 0;
        tick(); tick();
        compare_all("reset");

        rst = 0;
        for (int i = 0; i < 10; i++) begin
            free_run = 1'($urandom); rdy = 1'($urandom);
            tick();
            compare_all("idle");
        end

        seed = {8'($urandom), 8'($urandom), 8'h01};
        seed_valid = 1; free_run = 0; rdy = 0;
        tick();
        seed_valid = 0; rdy = 1;
        check("seq.first", 64'(rnd_a[OW-1:0]), 64'h01);
        compare_all("seq0");
`ifndef RNG_LEAP_EN
        for (int i = 1; i < 8; i++) begin
            tick();
            check("seq.table", 64'(rnd_a[OW-1:0]), 64'(seq8[i] & 32'h3F));
            check("seq.cnt", 64'(cnt_a), 64'(i));
            compare_all("seq");
        end
`else
        tick();
        check("leap.first", 64'(rnd_a[OW-1:0]), 64'h07);
        compare_all("leap");
`endif

        seed = {8'd78, 8'd0, 8'd127};
        seed_valid = 1; rdy = 0; free_run = 0;
        tick();
        seed_valid = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold.rnd", 64'(rnd_a), 64'({6'h0E, 6'h3F, 6'h3F}));
            compare_all("hold");
        end
        rdy = 1;
        for (int i = 0; i < 255; i++) begin
            tick();
            st0 = dut.state_q[7:0];
            check("nonzero", 64'(st0 != 8'd0), 64'd1);
            compare_all("run255");
        end
        check("period", 64'(dut.state_q[7:0]), 64'd127);

        cnt_before = cnt_a;
        seed = {8'($urandom), 8'($urandom), 8'($urandom)};
        seed_valid = 1; rdy = 1;
        tick();
        seed_valid = 0;
        check("reseed.cnt", 64'(cnt_a), 64'(cnt_before));
        compare_all("reseed");

        free_run = 1;
        for (int i = 0; i < 6; i++) begin
            rdy = 1'($urandom);
            tick();
            compare_all("free");
        end
        rst = 1;
        tick();
        check("midrst.valid", 64'(valid_a), 64'd0);
        compare_all("midrst");
        rst = 0; free_run = 0;
        seed = {8'($urandom), 8'($urandom), 8'($urandom)};
        seed_valid = 1;
        tick();
        seed_valid = 0; rdy = 1;
        for (int i = 0; i < 16; i++) tick();
        check("wrap.cnt4", 64'(cnt_b), 64'd0);
        check("wrap.cnt16", 64'(cnt_a), 64'd16);
        compare_all("wrap");

        for (int i = 0; i < 400; i++) begin
            seed_valid = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < NC; k++)
                seed[k*S +: S] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            free_run = 1'($urandom);
            rdy = 1'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            tick();
            compare_all("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
